// File: rtl/fft_frame_buffer.sv
// Ping-pong collector that packs prescaled audio samples into 4-word complex
// frames and hands each one to the FFT core through a start/done handshake.
module fft_frame_buffer #(
  parameter int SAMPLE_W = 16,
  parameter int PRESCALE = 2,
  parameter int CNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample_valid,
  input  logic [SAMPLE_W-1:0]   sample_in,
  input  logic                  fft_done,
  output logic                  start,
  output logic [2*SAMPLE_W-1:0] in0,
  output logic [2*SAMPLE_W-1:0] in1,
  output logic [2*SAMPLE_W-1:0] in2,
  output logic [2*SAMPLE_W-1:0] in3,
  output logic                  busy,
  output logic                  overrun,
  output logic [CNT_W-1:0]      drop_count
);

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

  state_t state_reg, state_next;

  // Address is {bank, index}: entries 0..3 are bank 0, 4..7 are bank 1.
  logic [SAMPLE_W-1:0] mem [0:7];
  logic [SAMPLE_W-1:0] frame_reg [0:3];

  logic [1:0]       full_reg;
  logic             wr_bank_reg;
  logic             rd_bank_reg;
  logic [1:0]       wr_idx_reg;
  logic             start_reg;
  logic             busy_reg;
  logic             overrun_reg;
  logic [CNT_W-1:0] drop_count_reg;

  logic signed [SAMPLE_W-1:0] scaled;
  logic accept, drop, launch, release_bank;

  assign scaled = $signed(sample_in) >>> PRESCALE;
  assign drop   = sample_valid &  full_reg[wr_bank_reg];
  assign accept = sample_valid & ~full_reg[wr_bank_reg];

  always_comb begin
    state_next   = state_reg;
    launch       = 1'b0;
    release_bank = 1'b0;
    case (state_reg)
      IDLE: begin
        // A done still high from the previous frame must not trigger a launch.
        if (full_reg[rd_bank_reg] && !fft_done) begin
          launch     = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (fft_done) begin
          release_bank = 1'b1;
          state_next   = GAP;
        end
      end
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      full_reg       <= 2'b00;
      wr_bank_reg    <= 1'b0;
      rd_bank_reg    <= 1'b0;
      wr_idx_reg     <= 2'd0;
      start_reg      <= 1'b0;
      busy_reg       <= 1'b0;
      overrun_reg    <= 1'b0;
      drop_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      // Release and frame completion always target different banks.
      if (release_bank) begin
        full_reg[rd_bank_reg] <= 1'b0;
        rd_bank_reg           <= ~rd_bank_reg;
        start_reg             <= 1'b0;
      end
      if (accept) begin
        wr_idx_reg <= wr_idx_reg + 2'd1;
        if (wr_idx_reg == 2'd3) begin
          full_reg[wr_bank_reg] <= 1'b1;
          wr_bank_reg           <= ~wr_bank_reg;
        end
      end
      if (launch) begin
        start_reg <= 1'b1;
        busy_reg  <= 1'b1;
      end
      if (state_reg == GAP)
        busy_reg <= 1'b0;
      if (drop) begin
        overrun_reg <= 1'b1;
        if (!(&drop_count_reg))
          drop_count_reg <= drop_count_reg + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept)
      mem[{wr_bank_reg, wr_idx_reg}] <= scaled;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++)
        frame_reg[i] <= '0;
    end else if (launch) begin
      for (int i = 0; i < 4; i++)
        frame_reg[i] <= mem[{rd_bank_reg, 2'(i)}];
    end
  end

  assign in0        = {frame_reg[0], {SAMPLE_W{1'b0}}};
  assign in1        = {frame_reg[1], {SAMPLE_W{1'b0}}};
  assign in2        = {frame_reg[2], {SAMPLE_W{1'b0}}};
  assign in3        = {frame_reg[3], {SAMPLE_W{1'b0}}};
  assign start      = start_reg;
  assign busy       = busy_reg;
  assign overrun    = overrun_reg;
  assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Bench for fft_frame_buffer: two instances (PRESCALE 0 and 2) driven in
// parallel and compared every cycle against a frame-queue reference model.
module tb_fft_frame_buffer;

  logic        clk = 1'b0;
  logic        reset, sample_valid, fft_done;
  logic [15:0] sample_in;

  logic        start_a, busy_a, overrun_a, start_b, busy_b, overrun_b;
  logic [7:0]  drop_a, drop_b;
  logic [31:0] a0, a1, a2, a3, b0, b1, b2, b3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fft_frame_buffer #(.SAMPLE_W(16), .PRESCALE(0), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_in(sample_in),
    .fft_done(fft_done), .start(start_a), .in0(a0), .in1(a1), .in2(a2), .in3(a3),
    .busy(busy_a), .overrun(overrun_a), .drop_count(drop_a));

  fft_frame_buffer #(.SAMPLE_W(16), .PRESCALE(2), .CNT_W(8)) dut_b (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_in(sample_in),
    .fft_done(fft_done), .start(start_b), .in0(b0), .in1(b1), .in2(b2), .in3(b3),
    .busy(busy_b), .overrun(overrun_b), .drop_count(drop_b));

  // Reference model: completed frames waiting for release, the partial frame
  // being gathered, and the frame currently presented to the core.
  logic [15:0] m_partial[$];
  logic [63:0] m_frames[$];
  logic [63:0] m_launched;
  int          m_phase;  // 0 idle, 1 frame with core, 2 gap cycle
  bit          m_start, m_busy, m_over;
  int          m_drops;

  function automatic logic [31:0] word(input logic [63:0] f, input int idx, input int p);
    logic signed [15:0] s;
    s = f[16*idx +: 16];
    s = s >>> p;
    return {s, 16'h0000};
  endfunction

  task automatic model_step(input logic v, input logic [15:0] s, input logic d, input logic r);
    int          cnt;
    bit          have_new;
    logic [63:0] newf;
    if (r) begin
      m_partial.delete();
      m_frames.delete();
      m_launched = '0;
      m_phase = 0; m_start = 0; m_busy = 0; m_over = 0; m_drops = 0;
      return;
    end
    cnt = m_frames.size();
    have_new = 0;
    newf = '0;
    if (v) begin
      if (cnt == 2) begin
        m_over = 1;
        if (m_drops < 255) m_drops++;
      end else begin
        m_partial.push_back(s);
        if (m_partial.size() == 4) begin
          newf = {m_partial[3], m_partial[2], m_partial[1], m_partial[0]};
          have_new = 1;
          m_partial.delete();
        end
      end
    end
    case (m_phase)
      0: if (cnt >= 1 && !d) begin
           m_launched = m_frames[0];
           m_start = 1; m_busy = 1; m_phase = 1;
         end
      1: if (d) begin
           m_start = 0;
           void'(m_frames.pop_front());
           m_phase = 2;
         end
      default: begin
        m_busy = 0;
        m_phase = 0;
      end
    endcase
    if (have_new) m_frames.push_back(newf);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("start_a", 64'(start_a), 64'(m_start));
    chk("busy_a", 64'(busy_a), 64'(m_busy));
    chk("overrun_a", 64'(overrun_a), 64'(m_over));
    chk("drop_a", 64'(drop_a), 64'(m_drops));
    chk("a_in0", 64'(a0), 64'(word(m_launched, 0, 0)));
    chk("a_in1", 64'(a1), 64'(word(m_launched, 1, 0)));
    chk("a_in2", 64'(a2), 64'(word(m_launched, 2, 0)));
    chk("a_in3", 64'(a3), 64'(word(m_launched, 3, 0)));
    chk("start_b", 64'(start_b), 64'(m_start));
    chk("busy_b", 64'(busy_b), 64'(m_busy));
    chk("overrun_b", 64'(overrun_b), 64'(m_over));
    chk("drop_b", 64'(drop_b), 64'(m_drops));
    chk("b_in0", 64'(b0), 64'(word(m_launched, 0, 2)));
    chk("b_in1", 64'(b1), 64'(word(m_launched, 1, 2)));
    chk("b_in2", 64'(b2), 64'(word(m_launched, 2, 2)));
    chk("b_in3", 64'(b3), 64'(word(m_launched, 3, 2)));
  endtask

  // One clock: drive inputs, take the edge, then compare just after it.
  task automatic cyc(input logic v, input logic [15:0] s, input logic d, input logic r);
    sample_valid = v; sample_in = s; fft_done = d; reset = r;
    @(posedge clk);
    model_step(v, s, d, r);
    #1;
    check_all();
  endtask

  initial begin
    reset = 1'b1; sample_valid = 1'b0; sample_in = '0; fft_done = 1'b0;
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("rst_start", 64'(start_a), 64'd0);
    chk("rst_in0", 64'(a0), 64'd0);

    // Frame 0,1,2,3: start appears two cycles after the 4th sample
    for (int i = 0; i < 4; i++) cyc(1, 16'(i), 0, 0);
    chk("t1_start_k1", 64'(start_a), 64'd0);
    cyc(0, 0, 0, 0);
    chk("t1_start_k2", 64'(start_a), 64'd1);
    chk("t1_in0", 64'(a0), 64'h00000000);
    chk("t1_in1", 64'(a1), 64'h00010000);
    chk("t1_in2", 64'(a2), 64'h00020000);
    chk("t1_in3", 64'(a3), 64'h00030000);

    // Second frame fills the other bank while the core holds the first
    cyc(1, 16'd4, 0, 0);
    cyc(1, 16'd8, 0, 0);
    cyc(1, 16'hFFFC, 0, 0);
    cyc(1, 16'h8000, 0, 0);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0);
    chk("t3_hold_start", 64'(start_a), 64'd1);
    chk("t3_hold_in1", 64'(a1), 64'h00010000);
    cyc(0, 0, 1, 0);
    chk("t3_start_drop", 64'(start_a), 64'd0);
    chk("t3_busy_held", 64'(busy_a), 64'd1);
    cyc(0, 0, 0, 0);
    chk("t3_busy_drop", 64'(busy_a), 64'd0);
    chk("t3_gap_start", 64'(start_a), 64'd0);
    cyc(0, 0, 0, 0);
    chk("t3_restart", 64'(start_b), 64'd1);
    chk("t2_in0", 64'(b0), 64'h00010000);
    chk("t2_in1", 64'(b1), 64'h00020000);
    chk("t2_in2", 64'(b2), 64'hFFFF0000);
    chk("t2_in3", 64'(b3), 64'hE0000000);
    cyc(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);

    // Overrun: 12 samples with the core never finishing
    for (int i = 0; i < 12; i++) cyc(1, 16'(100 + i), 0, 0);
    chk("t4_overrun", 64'(overrun_a), 64'd1);
    chk("t4_drops", 64'(drop_a), 64'd4);
    for (int i = 0; i < 296; i++) cyc(1, 16'($urandom), 0, 0);
    chk("t5_sat", 64'(drop_b), 64'd255);

    // Reset while BUSY, then with a partial frame pending
    cyc(0, 0, 0, 1);
    chk("t6_rst_busy", 64'(busy_a), 64'd0);
    cyc(1, 16'd77, 0, 0);
    cyc(1, 16'd78, 0, 0);
    cyc(0, 0, 0, 1);
    chk("t6_rst_start", 64'(start_a), 64'd0);
    chk("t6_rst_in3", 64'(a3), 64'd0);
    for (int i = 5; i <= 8; i++) cyc(1, 16'(i), 0, 0);
    cyc(0, 0, 0, 0);
    chk("t6_in0", 64'(a0), 64'h00050000);
    chk("t6_in3", 64'(a3), 64'h00080000);
    cyc(0, 0, 1, 0);

    // Stale done held high while a frame waits: no launch
    for (int i = 0; i < 4; i++) cyc(1, 16'(i + 9), 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
    chk("stale_done", 64'(start_a), 64'd0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 1500; i++)
      cyc(logic'($urandom_range(0, 9) < 6), 16'($urandom),
          logic'($urandom_range(0, 9) == 0), logic'($urandom_range(0, 299) == 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fft_frame_buffer.md
Name: fft_frame_buffer

Overview:
- Upstream stage of the 4-point FFT core.
- Collects a stream of signed audio samples into 4-sample frames using ping-pong storage.
- Presents each frame as four packed complex words: real in [31:16], imaginary in [15:0].
- Drives the core's start/done handshake so the core always sees a stable frame, while new samples keep filling the other bank.

Parameters:
- SAMPLE_W, 16: width of the input sample and of each real/imag half of a frame word. Frame words are 2*SAMPLE_W wide.
- PRESCALE, 2: arithmetic right shift applied to each sample before storage. It provides headroom for FFT bit growth. Legal range 0 to SAMPLE_W-1.
- CNT_W, 8: width of the saturating drop counter.

Ports:
- clk, in, 1: system clock; all logic is on its rising edge.
- reset, in, 1: synchronous, active-high reset.
- sample_valid, in, 1: sample_in is accepted on this cycle.
- sample_in, in, SAMPLE_W: signed two's-complement audio sample.
- fft_done, in, 1: done flag from the FFT core.
- start, out, 1: start request to the FFT core.
- in0, in1, in2, in3, out, 2*SAMPLE_W each: frame words for the core. in0 is the oldest sample.
- busy, out, 1: high while a frame is launched and not yet released.
- overrun, out, 1: sticky flag, set on the first dropped sample.
- drop_count, out, CNT_W: number of dropped samples, saturating.

Behaviour:
- Reset (synchronous, any state) clears the following, and any partial frame is discarded:
  - start=0, busy=0, overrun=0, drop_count=0;
  - in0..in3 = 0;
  - both banks empty;
  - wr_bank=0, rd_bank=0, write index=0;
  - FSM returns to IDLE.
- Storage format:
  - Stored value = sample_in >>> PRESCALE, sign-extended back to SAMPLE_W.
  - Frame word = {scaled_sample, SAMPLE_W'b0}; imaginary is always 0.
- Write side:
  - A sample with sample_valid=1 goes to bank wr_bank at the current index (0..3).
  - Index 3 write: the bank is marked full from the next cycle, the index wraps to 0, and wr_bank toggles.
  - If bank wr_bank is still full (both banks full), the sample is dropped: overrun set, drop_count increments (holds at all-ones), index and pointers unchanged.
- Read FSM states: IDLE, BUSY, GAP.
  - IDLE, when bank rd_bank is full and fft_done=0: at the next edge, in0..in3 load from that bank, start=1, busy=1, go to BUSY.
  - IDLE, when bank rd_bank is full but fft_done=1 (stale done): wait in IDLE.
  - BUSY: start and in0..in3 are held stable. When fft_done=1 is sampled, at the next edge: start=0, bank rd_bank cleared to empty, rd_bank toggles, go to GAP. busy stays 1.
  - GAP: exactly one cycle with start=0, so the core sees start low between frames. Then busy=0 and go to IDLE.
- Latency:
  - 4th sample valid in cycle k → start=1 in cycle k+2, provided the FSM is in IDLE and fft_done=0.
  - fft_done=1 in cycle d → start=0 in cycle d+1 → earliest next start in cycle d+3.
- Simultaneous events:
  - A bank released at edge e is writable from cycle e+1.
  - A sample arriving in the same cycle as a release while both banks are full is dropped.
  - A write and a launch in the same cycle touch different banks; both proceed.
- Ordering: frames are delivered in arrival order. A frame is never split across banks.
- in0..in3 change only at a launch edge or at reset.

Test Plan:
1. PRESCALE=0; samples 0,1,2,3 on consecutive cycles; fft_done=0 → start rises 2 cycles after the 4th sample. in0=0x00000000, in1=0x00010000, in2=0x00020000, in3=0x00030000.
2. PRESCALE=2; samples 4,8,-4,-32768 → in0=0x00010000, in1=0x00020000, in2=0xFFFF0000, in3=0xE0000000.
3. Handshake: hold fft_done=0 for 20 cycles after start, then pulse it for 1 cycle.
   - start stays high with frame stable throughout.
   - start drops 1 cycle after done; busy drops 2 cycles after done.
   - With a second frame already full, the next start follows 3 cycles after done, carrying that frame.
4. Overrun: fft_done tied 0; stream 12 samples → first 8 fill both banks, last 4 dropped. overrun=1, drop_count=4.
5. Saturation, CNT_W=8: 300 dropped samples → drop_count=255.
6. Reset mid-operation: 2 samples written, then reset for 1 cycle, then 4 samples 5,6,7,8 with PRESCALE=0. Reset must also be asserted while BUSY.
   - During/after reset: start=0, in0..in3 all 0.
   - The new frame is in0=0x00050000 .. in3=0x00080000; the pre-reset samples never appear.
